// File: rtl/alu_reg_seq.sv
// Command sequencer for an ALU/register-file pair. It accepts one command at a
// time and walks it through READ -> EXEC -> WB -> DONE, one cycle per state.
// It captures the result flags at the end of EXEC and keeps a saturating count
// of overflow events.
//
// Handshake: a command transfers on a rising Clk edge where Cmd_Valid and
// Cmd_Ready are both 1. Cmd_Ready is 1 only in IDLE. Cmd_* inputs are ignored
// at every other edge, and Cmd_Valid may stay high while the sequencer is busy.
module alu_reg_seq #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic [2:0]       Cmd_OP,
    input  logic [4:0]       Cmd_RA,
    input  logic [4:0]       Cmd_RB,
    input  logic [4:0]       Cmd_RW,
    input  logic             Cmd_WB,
    output logic [4:0]       R_Addr_A,
    output logic [4:0]       R_Addr_B,
    output logic [4:0]       W_Addr,
    output logic [2:0]       ALU_OP,
    output logic             Write_Reg,
    input  logic             ZF,
    input  logic             OF,
    output logic             Done,
    output logic             Res_ZF,
    output logic             Res_OF,
    output logic             Busy,
    output logic [CNT_W-1:0] Ovf_Cnt,
    input  logic             Cnt_Clr,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_n;
    logic   wb_q;
    logic   accept;

    // The accept decode uses the state directly, so the ready output is not
    // fed back into the next-state logic.
    assign accept    = Cmd_Valid && (state == S_IDLE);
    assign dbg_state = state;

    // State register. Reset returns the FSM to IDLE without waiting for a
    // clock edge, which aborts any command in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and the outputs that are decoded from the state.
    // Write_Reg is decoded from the state, so an asynchronous reset drops it
    // at once.
    always_comb begin
        state_n   = state;
        Cmd_Ready = 1'b0;
        Done      = 1'b0;
        Write_Reg = 1'b0;
        case (state)
            S_IDLE: begin
                Cmd_Ready = 1'b1;
                if (accept) begin
                    state_n = S_READ;
                end
            end
            S_READ: state_n = S_EXEC;
            S_EXEC: state_n = S_WB;
            S_WB: begin
                state_n   = S_DONE;
                // Register 0 is never written.
                Write_Reg = wb_q && (W_Addr != 5'd0);
            end
            S_DONE: begin
                state_n = S_IDLE;
                Done    = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign Busy = ~Cmd_Ready;

    // Capture the command fields on acceptance. The ALU control outputs hold
    // these values through the command and keep them in IDLE afterwards.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            R_Addr_A <= 5'd0;
            R_Addr_B <= 5'd0;
            W_Addr   <= 5'd0;
            ALU_OP   <= 3'd0;
            wb_q     <= 1'b0;
        end else if (accept) begin
            R_Addr_A <= Cmd_RA;
            R_Addr_B <= Cmd_RB;
            W_Addr   <= Cmd_RW;
            ALU_OP   <= Cmd_OP;
            wb_q     <= Cmd_WB;
        end
    end

    // Sample the ALU flags on the edge that leaves EXEC. They are held until
    // the next command leaves EXEC.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Res_ZF <= 1'b0;
            Res_OF <= 1'b0;
        end else if (state == S_EXEC) begin
            Res_ZF <= ZF;
            Res_OF <= OF;
        end
    end

    // Saturating overflow counter. A clear wins over an increment at the same
    // edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Ovf_Cnt <= '0;
        end else if (Cnt_Clr) begin
            Ovf_Cnt <= '0;
        end else if ((state == S_EXEC) && OF && (Ovf_Cnt != CNT_MAX)) begin
            Ovf_Cnt <= Ovf_Cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_reg_seq.sv
// Bench for alu_reg_seq. It runs a table of commands through the sequencer
// back to back, then runs a hand-written reset-during-WB sequence.
module tb_alu_reg_seq;

    localparam int CNT_W = 2;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Cmd_Valid;
    logic             Cmd_Ready;
    logic [2:0]       Cmd_OP;
    logic [4:0]       Cmd_RA;
    logic [4:0]       Cmd_RB;
    logic [4:0]       Cmd_RW;
    logic             Cmd_WB;
    logic [4:0]       R_Addr_A;
    logic [4:0]       R_Addr_B;
    logic [4:0]       W_Addr;
    logic [2:0]       ALU_OP;
    logic             Write_Reg;
    logic             ZF;
    logic             OF;
    logic             Done;
    logic             Res_ZF;
    logic             Res_OF;
    logic             Busy;
    logic [CNT_W-1:0] Ovf_Cnt;
    logic             Cnt_Clr;
    logic [2:0]       dbg_state;

    alu_reg_seq #(.CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Cmd_Valid (Cmd_Valid),
        .Cmd_Ready (Cmd_Ready),
        .Cmd_OP    (Cmd_OP),
        .Cmd_RA    (Cmd_RA),
        .Cmd_RB    (Cmd_RB),
        .Cmd_RW    (Cmd_RW),
        .Cmd_WB    (Cmd_WB),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .ALU_OP    (ALU_OP),
        .Write_Reg (Write_Reg),
        .ZF        (ZF),
        .OF        (OF),
        .Done      (Done),
        .Res_ZF    (Res_ZF),
        .Res_OF    (Res_OF),
        .Busy      (Busy),
        .Ovf_Cnt   (Ovf_Cnt),
        .Cnt_Clr   (Cnt_Clr),
        .dbg_state (dbg_state)
    );

    // Clock: rising edges at 5, 15, 25, ...; inputs change and outputs are
    // sampled on falling edges.
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] op;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rw;
        logic       wb;
        logic       zf;
        logic       of;
        logic       clr;
        logic       exp_wr;
        logic [1:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    logic [1:0] exp_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic       prev_zf  = 1'b0;
    logic       prev_of  = 1'b0;
    logic [1:0] prev_cnt = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_garbage();
        Cmd_OP = 3'($urandom_range(0, 7));
        Cmd_RA = 5'($urandom_range(0, 31));
        Cmd_RB = 5'($urandom_range(0, 31));
        Cmd_RW = 5'($urandom_range(0, 31));
        Cmd_WB = 1'($urandom_range(0, 1));
    endtask

    // One command. The task enters just after a falling edge, with the DUT in
    // IDLE or in DONE. While the command is busy, Cmd_Valid stays high and the
    // fields are random; none of that may be accepted or take effect. The
    // flags are driven inverted outside EXEC, so sampling on any other edge
    // shows up.
    task automatic do_cmd(input vec_t v, input bit last);
        @(negedge Clk);
        Cmd_Valid = 1'b1;
        Cmd_OP = v.op; Cmd_RA = v.ra; Cmd_RB = v.rb; Cmd_RW = v.rw; Cmd_WB = v.wb;
        ZF = ~v.zf; OF = ~v.of; Cnt_Clr = 1'b0;
        check("ready_idle", 32'(Cmd_Ready), 32'd1);
        check("busy_idle", 32'(Busy), 32'd0);
        @(posedge Clk);
        exp_q.push_back({v.zf, v.of});
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            if (k == 1) drive_garbage();
            if (k == 2) begin
                ZF = v.zf; OF = v.of; Cnt_Clr = v.clr;
            end
            if (k == 3) begin
                ZF = ~v.zf; OF = ~v.of; Cnt_Clr = 1'b0;
            end
            check("ready_busy", 32'(Cmd_Ready), 32'd0);
            check("busy", 32'(Busy), 32'd1);
            check("done", 32'(Done), (k == 4) ? 32'd1 : 32'd0);
            check("write_reg", 32'(Write_Reg), (k == 3) ? 32'(v.exp_wr) : 32'd0);
            check("r_addr_a", 32'(R_Addr_A), 32'(v.ra));
            check("r_addr_b", 32'(R_Addr_B), 32'(v.rb));
            check("w_addr", 32'(W_Addr), 32'(v.rw));
            check("alu_op", 32'(ALU_OP), 32'(v.op));
            if (k <= 2) begin
                check("res_zf_hold", 32'(Res_ZF), 32'(prev_zf));
                check("res_of_hold", 32'(Res_OF), 32'(prev_of));
                check("ovf_cnt_hold", 32'(Ovf_Cnt), 32'(prev_cnt));
            end else begin
                check("ovf_cnt", 32'(Ovf_Cnt), 32'(v.exp_cnt));
            end
            if (Done) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("res_flags", 32'({Res_ZF, Res_OF}), 32'(exp_q.pop_front()));
                end
            end
        end
        if (last) Cmd_Valid = 1'b0;
        prev_zf  = v.zf;
        prev_of  = v.of;
        prev_cnt = v.exp_cnt;
    endtask

    initial begin
        // op, ra, rb, rw, wb, zf, of, clr, exp_wr, exp_cnt
        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[1] = '{3'd5, 5'd7,  5'd8,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{3'd2, 5'd31, 5'd0,  5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3] = '{3'd7, 5'd4,  5'd5,  5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
        vecs[4] = '{3'd1, 5'd9,  5'd10, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
        vecs[5] = '{3'd3, 5'd12, 5'd13, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
        vecs[6] = '{3'd4, 5'd15, 5'd16, 5'd17, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3};
        vecs[7] = '{3'd6, 5'd18, 5'd19, 5'd20, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0};
        vecs[8] = '{3'd0, 5'd21, 5'd22, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[9] = '{3'd2, 5'd30, 5'd29, 5'd28, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};

        // Reset values, checked with Reset held across rising edges.
        Reset = 1'b1; Cmd_Valid = 1'b0; Cnt_Clr = 1'b0; ZF = 1'b1; OF = 1'b1;
        drive_garbage();
        repeat (2) @(negedge Clk);
        check("rst_ready", 32'(Cmd_Ready), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_write_reg", 32'(Write_Reg), 32'd0);
        check("rst_addrs", 32'({R_Addr_A, R_Addr_B, W_Addr, ALU_OP}), 32'd0);
        check("rst_flags", 32'({Res_ZF, Res_OF}), 32'd0);
        check("rst_ovf_cnt", 32'(Ovf_Cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        Reset = 1'b0;

        // Table commands, back to back with Cmd_Valid held high.
        for (int i = 0; i < NVEC; i++) begin
            do_cmd(vecs[i], i == NVEC - 1);
        end

        // Reset during WB: Write_Reg falls without a clock edge and the
        // command ends without Done.
        @(negedge Clk);
        Cmd_Valid = 1'b1; Cmd_OP = 3'd1; Cmd_RA = 5'd2; Cmd_RB = 5'd3;
        Cmd_RW = 5'd5; Cmd_WB = 1'b1; ZF = 1'b0; OF = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Cmd_Valid = 1'b0;
        repeat (2) @(negedge Clk);
        check("wb_write_reg", 32'(Write_Reg), 32'd1);
        check("wb_ovf_cnt_before", 32'(Ovf_Cnt), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_write_reg", 32'(Write_Reg), 32'd0);
        check("arst_ready", 32'(Cmd_Ready), 32'd1);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_done", 32'(Done), 32'd0);
        check("arst_addrs", 32'({R_Addr_A, R_Addr_B, W_Addr, ALU_OP}), 32'd0);
        check("arst_flags", 32'({Res_ZF, Res_OF}), 32'd0);
        check("arst_ovf_cnt", 32'(Ovf_Cnt), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        exp_q.delete();
        prev_zf = 1'b0; prev_of = 1'b0; prev_cnt = 2'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            check("post_rst_done", 32'(Done), 32'd0);
            check("post_rst_ready", 32'(Cmd_Ready), 32'd1);
            check("post_rst_write_reg", 32'(Write_Reg), 32'd0);
        end

        // The sequencer accepts and completes a command again after reset.
        do_cmd(vecs[0], 1'b1);
        @(negedge Clk);
        check("final_ready", 32'(Cmd_Ready), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_reg_seq.md
ALU_REG_SEQ -- requirements
Module: alu_reg_seq

Interface
REQ-001 SHALL expose parameter CNT_W, default 8: width of the overflow event counter.
REQ-002 SHALL have port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1: reset is asynchronous and active-high; one clock domain only.
REQ-004 SHALL have port Cmd_Valid, input, 1: command offered.
REQ-005 SHALL have port Cmd_Ready, output, 1: sequencer can accept a command.
REQ-006 SHALL have ports Cmd_OP, Cmd_RA, Cmd_RB and Cmd_RW, inputs, widths 3/5/5/5: ALU operation, source A address, source B address, destination address.
REQ-007 SHALL have port Cmd_WB, input, 1: write result back to the register file.
REQ-008 SHALL have ports R_Addr_A, R_Addr_B, W_Addr, ALU_OP and Write_Reg, outputs, widths 5/5/5/3/1: drive the ALU_REG control inputs.
REQ-009 SHALL have ports ZF and OF, inputs, 1 each: flags returned by ALU_REG.
REQ-010 SHALL have port Done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have ports Res_ZF and Res_OF, outputs, 1 each: flags of the last completed command.
REQ-012 SHALL have port Busy, output, 1: a command is in flight.
REQ-013 SHALL have port Ovf_Cnt, output, CNT_W: saturating count of overflow events.
REQ-014 SHALL have port Cnt_Clr, input, 1: synchronous clear of Ovf_Cnt.

Function
REQ-015 SHALL implement states IDLE -> READ -> EXEC -> WB -> DONE -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-016 SHALL assert Cmd_Ready only in IDLE; Busy SHALL equal NOT Cmd_Ready.
REQ-017 SHALL accept a command at a rising edge where Cmd_Valid=1 and Cmd_Ready=1, and SHALL then capture all Cmd_* fields.
REQ-018 SHALL hold Cmd_* fields as don't-care while Busy=1; they SHALL have no effect.
REQ-019 SHALL drive R_Addr_A, R_Addr_B, W_Addr and ALU_OP from the captured fields from READ through DONE.
REQ-020 SHALL hold R_Addr_A, R_Addr_B, W_Addr and ALU_OP at their last values in IDLE.
REQ-021 SHALL sample ZF and OF into Res_ZF and Res_OF at the edge leaving EXEC.
REQ-022 SHALL assert Write_Reg only in WB, and only when the captured WB bit is 1 and the captured RW is not 0; otherwise Write_Reg SHALL be 0, and writes to register 0 are suppressed.
REQ-023 SHALL pulse Done high during DONE for exactly one cycle.
REQ-024 SHALL hold Res_ZF and Res_OF until the next EXEC exit.
REQ-025 SHALL give a latency of 4 cycles from the acceptance edge to Done high, and SHALL accept the next command no earlier than the edge after DONE (one command per 5 cycles).
REQ-026 SHALL increment Ovf_Cnt at the EXEC exit edge when OF=1.
REQ-027 SHALL saturate Ovf_Cnt at 2^CNT_W-1 with no wrap.
REQ-028 SHALL give Cnt_Clr priority over a simultaneous increment, leaving Ovf_Cnt at 0.

Reset
REQ-029 SHALL, on Reset=1, immediately (without waiting for a clock edge) force state IDLE.
REQ-030 SHALL, on Reset=1, force Write_Reg, Done, Res_ZF, Res_OF and Ovf_Cnt to 0.
REQ-031 SHALL, on Reset=1, force R_Addr_A, R_Addr_B, W_Addr and ALU_OP to 0.
REQ-032 SHALL, on Reset=1, force Cmd_Ready=1 and Busy=0 while Reset is high.
REQ-033 SHALL abort an in-flight command on Reset with no Done, and SHALL drop Write_Reg asynchronously if it is high.

Verification
REQ-034 SHALL cover a basic command: OP=0, RA=1, RB=2, RW=3, WB=1 accepted at edge T, ZF=0, OF=0 -> Write_Reg=1 only in cycle T+3, W_Addr=3, Done=1 in T+4, Res_ZF=0.
REQ-035 SHALL cover zero destination: RW=0, WB=1 -> Write_Reg stays 0 for the whole command, and Done still pulses at T+4.
REQ-036 SHALL cover back-to-back commands: Cmd_Valid held high for two commands -> the second is accepted at T+5, and Cmd_Ready=0 during T+1..T+4.
REQ-037 SHALL cover counter saturation and clear: CNT_W=2, four commands with OF=1 -> Ovf_Cnt=3 after the third and fourth; Cnt_Clr asserted at the same edge as an OF increment -> Ovf_Cnt=0.
REQ-038 SHALL cover reset during a command: Reset asserted mid-WB -> Write_Reg falls immediately, no Done, and Cmd_Ready=1 after release.
